// File: rtl/multicycle_controller.sv
// Moore sequencer for the multi-cycle MIPS datapath: one shared memory and ALU,
// control strobes decoded from the registered state plus the opcode/func latched in DECODE.
module multicycle_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             jal_reg,
    output logic             pc_to_reg,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_cntrl,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ILLEGAL
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    state_t     state, state_nxt;
    logic [5:0] op_q, fn_q;
    logic       r_ok;
    logic [2:0] r_alu;
    logic       retire;

    // The branch decision is made in the datapath (pc_write_cond & zero).
    logic unused_zero;
    assign unused_zero = zero;

    // R-type ALU function from the func latched in DECODE.
    always_comb begin
        r_ok  = 1'b1;
        r_alu = 3'b010;
        case (fn_q)
            6'b100000: r_alu = 3'b010;
            6'b100010: r_alu = 3'b110;
            6'b100100: r_alu = 3'b000;
            6'b100101: r_alu = 3'b001;
            6'b101010: r_alu = 3'b111;
            default: begin
                r_ok  = 1'b0;
                r_alu = 3'b000;
            end
        endcase
    end

    // Leaving any state other than INIT for FETCH is an instruction completing.
    assign retire = (state_nxt == S_FETCH) && (state != S_INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_INIT;
            op_q        <= '0;
            fn_q        <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q <= opcode;
                fn_q <= func;
            end
            if (state_nxt == S_ILLEGAL)
                illegal <= 1'b1;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
                    OP_R:             state_nxt = (func == FN_JR) ? S_JR : S_R_EXEC;
                    OP_ADDI, OP_SLTI: state_nxt = S_I_EXEC;
                    OP_BEQ:           state_nxt = S_BRANCH;
                    OP_J:             state_nxt = S_JUMP;
                    OP_JAL:           state_nxt = S_JAL;
                    default:          state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: state_nxt = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_nxt = S_MEM_WB;
            S_R_EXEC:   state_nxt = r_ok ? S_R_WB : S_ILLEGAL;
            S_I_EXEC:   state_nxt = S_I_WB;
            S_ILLEGAL:  state_nxt = S_ILLEGAL;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB,
            S_BRANCH, S_JUMP, S_JAL, S_JR:
                        state_nxt = S_FETCH;
            default:    state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        jal_reg       = 1'b0;
        pc_to_reg     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_cntrl     = 3'b000;
        pc_src        = 2'b00;
        case (state)
            S_INIT:   alu_cntrl = 3'b010;
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                alu_cntrl = 3'b010;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_cntrl = 3'b010;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_cntrl = 3'b010;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_cntrl = r_alu;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_cntrl = (op_q == OP_SLTI) ? 3'b111 : 3'b010;
            end
            S_I_WB:   reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_cntrl     = 3'b110;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                pc_src    = 2'b10;
                reg_write = 1'b1;
                jal_reg   = 1'b1;
                pc_to_reg = 1'b1;
            end
            S_JR: begin
                alu_src_a = 1'b1;
                pc_write  = 1'b1;
                pc_src    = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-cycle control-vector sequences per instruction, illegal handling,
// mid-instruction reset, and counter wrap on a CNT_W=2 instance.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode, func;
    logic        zero;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, jal_reg, pc_to_reg, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_cntrl;
    logic        illegal;
    logic [15:0] instr_count;

    logic [11:0] unused_bits;
    logic [1:0]  unused_asb, unused_psrc;
    logic [2:0]  unused_alu;
    logic        unused_ill;
    logic [1:0]  cnt2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .jal_reg(jal_reg), .pc_to_reg(pc_to_reg),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_cntrl(alu_cntrl), .pc_src(pc_src),
        .illegal(illegal), .instr_count(instr_count)
    );

    multicycle_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .pc_write(unused_bits[0]), .pc_write_cond(unused_bits[1]), .i_or_d(unused_bits[2]),
        .mem_read(unused_bits[3]), .mem_write(unused_bits[4]), .ir_write(unused_bits[5]),
        .reg_dst(unused_bits[6]), .jal_reg(unused_bits[7]), .pc_to_reg(unused_bits[8]),
        .mem_to_reg(unused_bits[9]), .reg_write(unused_bits[10]), .alu_src_a(unused_bits[11]),
        .alu_src_b(unused_asb), .alu_cntrl(unused_alu), .pc_src(unused_psrc),
        .illegal(unused_ill), .instr_count(cnt2)
    );

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst, jal_reg,
    //  pc_to_reg, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], alu_cntrl[2:0], pc_src[1:0]}
    logic [18:0] vec;
    assign vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                  jal_reg, pc_to_reg, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_cntrl,
                  pc_src};

    localparam logic [18:0] V_INIT   = 19'h00008;
    localparam logic [18:0] V_FETCH  = 19'h4A028;
    localparam logic [18:0] V_DECODE = 19'h00068;
    localparam logic [18:0] V_MADDR  = 19'h000C8;
    localparam logic [18:0] V_MRD    = 19'h18000;
    localparam logic [18:0] V_MWB    = 19'h00300;
    localparam logic [18:0] V_MWR    = 19'h14000;
    localparam logic [18:0] V_R_SUB  = 19'h00098;
    localparam logic [18:0] V_R_SLT  = 19'h0009C;
    localparam logic [18:0] V_R_WB   = 19'h01100;
    localparam logic [18:0] V_ADDI   = 19'h000C8;
    localparam logic [18:0] V_SLTI   = 19'h000DC;
    localparam logic [18:0] V_I_WB   = 19'h00100;
    localparam logic [18:0] V_BRANCH = 19'h20099;
    localparam logic [18:0] V_JAL    = 19'h40D02;
    localparam logic [18:0] V_JR     = 19'h40083;

    logic [18:0] seq [0:5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expects to start in FETCH; opcode is scrambled once DECODE is past to show it is ignored.
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int n, input int cnt);
        opcode = op;
        func   = fn;
        zero   = z;
        for (int i = 0; i < n; i++) begin
            if (i >= 2) opcode = ~op;
            chk($sformatf("%s_c%0d", tag, i), {13'd0, vec}, {13'd0, seq[i]});
            step();
        end
        chk({tag, "_cnt"}, {16'd0, instr_count}, cnt);
        chk({tag, "_cnt2"}, {30'd0, cnt2}, cnt % 4);
    endtask

    initial begin
        rst = 1'b1; opcode = '0; func = '0; zero = 1'b0;
        step();
        chk("rst_vec", {13'd0, vec}, {13'd0, V_INIT});
        chk("rst_ill", {31'd0, illegal}, 0);
        chk("rst_cnt", {16'd0, instr_count}, 0);
        rst = 1'b0;
        chk("init_vec", {13'd0, vec}, {13'd0, V_INIT});
        step();

        seq = '{V_FETCH, V_DECODE, V_MADDR, V_MRD, V_MWB, 19'h0};
        run("lw", 6'b100011, 6'b000000, 1'b0, 5, 1);
        seq = '{V_FETCH, V_DECODE, V_R_SUB, V_R_WB, 19'h0, 19'h0};
        run("sub", 6'b000000, 6'b100010, 1'b0, 4, 2);
        seq = '{V_FETCH, V_DECODE, V_R_SLT, V_R_WB, 19'h0, 19'h0};
        run("slt", 6'b000000, 6'b101010, 1'b0, 4, 3);
        seq = '{V_FETCH, V_DECODE, V_BRANCH, 19'h0, 19'h0, 19'h0};
        run("beq_z1", 6'b000100, 6'b000000, 1'b1, 3, 4);
        run("beq_z0", 6'b000100, 6'b000000, 1'b0, 3, 5);
        seq = '{V_FETCH, V_DECODE, V_JAL, 19'h0, 19'h0, 19'h0};
        run("jal", 6'b000011, 6'b000000, 1'b0, 3, 6);
        seq = '{V_FETCH, V_DECODE, V_JR, 19'h0, 19'h0, 19'h0};
        run("jr", 6'b000000, 6'b001000, 1'b0, 3, 7);
        seq = '{V_FETCH, V_DECODE, V_ADDI, V_I_WB, 19'h0, 19'h0};
        run("addi", 6'b001000, 6'b000000, 1'b0, 4, 8);
        seq = '{V_FETCH, V_DECODE, V_SLTI, V_I_WB, 19'h0, 19'h0};
        run("slti", 6'b001010, 6'b000000, 1'b0, 4, 9);
        seq = '{V_FETCH, V_DECODE, V_MADDR, V_MWR, 19'h0, 19'h0};
        run("sw", 6'b101011, 6'b000000, 1'b0, 4, 10);
        seq = '{V_FETCH, 19'h40002, 19'h0, 19'h0, 19'h0, 19'h0};
        seq[1] = V_DECODE;
        seq[2] = 19'h40002;
        run("j", 6'b000010, 6'b000000, 1'b0, 3, 11);

        // Illegal opcode: absorbing, strobes low, counter frozen.
        opcode = 6'b111111;
        chk("ilop_fetch", {13'd0, vec}, {13'd0, V_FETCH});
        step();
        chk("ilop_decode", {13'd0, vec}, {13'd0, V_DECODE});
        step();
        opcode = 6'b100011;
        for (int i = 0; i < 20; i++) begin
            chk("ilop_vec", {13'd0, vec}, 0);
            chk("ilop_flag", {31'd0, illegal}, 1);
            step();
        end
        chk("ilop_cnt", {16'd0, instr_count}, 11);
        chk("ilop_cnt2", {30'd0, cnt2}, 3);

        rst = 1'b1;
        #1;
        chk("ilop_rst_flag", {31'd0, illegal}, 0);
        chk("ilop_rst_cnt", {16'd0, instr_count}, 0);
        chk("ilop_rst_vec", {13'd0, vec}, {13'd0, V_INIT});
        step();
        rst = 1'b0;
        step();

        // Illegal R-type func.
        opcode = 6'b000000;
        func   = 6'b000111;
        chk("ilfn_fetch", {13'd0, vec}, {13'd0, V_FETCH});
        step();
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            chk("ilfn_vec", {13'd0, vec}, 0);
            chk("ilfn_flag", {31'd0, illegal}, 1);
            step();
        end
        chk("ilfn_cnt", {16'd0, instr_count}, 0);

        // Reset pulsed while MEM_WR is driving mem_write.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        opcode = 6'b101011;
        step();
        step();
        step();
        chk("mwr_vec", {13'd0, vec}, {13'd0, V_MWR});
        #2 rst = 1'b1;
        #1;
        chk("mwr_rst_wr", {31'd0, mem_write}, 0);
        chk("mwr_rst_vec", {13'd0, vec}, {13'd0, V_INIT});
        step();
        rst = 1'b0;
        chk("mwr_rel_vec", {13'd0, vec}, {13'd0, V_INIT});
        step();
        chk("mwr_fetch", {13'd0, vec}, {13'd0, V_FETCH});
        chk("mwr_cnt", {16'd0, instr_count}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
